// File: rtl/rt_datapath_seq.sv
// Self-sequencing single-bus datapath: register file, PC/IR, HI/LO, ALU and I/O ports,
// driven by an internal T-step controller over a ready/ack memory handshake.
module rt_datapath_seq #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 9,
    parameter int RESET_PC = 0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic              busy,
    output logic              halted,
    output logic              err,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int                RIDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);
    localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8,  OP_ADDI = 5'd9,  OP_ANDI = 5'd10, OP_MUL  = 5'd11;
    localparam logic [4:0] OP_IN   = 5'd12, OP_OUT  = 5'd13, OP_MFHI = 5'd14, OP_MFLO = 5'd15;
    localparam logic [4:0] OP_NOP  = 5'd16, OP_HALT = 5'd17;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [ADDR_W-1:0]   r_pc;
    logic [31:0]         r_ir;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_y;
    logic [DATA_W-1:0]   r_z;
    logic [DATA_W-1:0]   r_out;
    logic                r_err;

    logic [4:0]          w_op;
    logic [3:0]          w_ra;
    logic [3:0]          w_rb;
    logic [3:0]          w_rc;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W-1:0]   w_ra_val;
    logic [DATA_W-1:0]   w_rb_val;
    logic [DATA_W-1:0]   w_rc_val;
    logic [DATA_W-1:0]   w_b_val;
    logic                w_use_imm;
    logic                w_base;
    logic [DATA_W-1:0]   w_alu;
    logic [2*DATA_W-1:0] w_ye;
    logic [2*DATA_W-1:0] w_ze;
    logic [2*DATA_W-1:0] w_prod;

    function automatic logic reg_ok(input logic [3:0] idx);
        return int'(idx) < NUM_REGS;
    endfunction

    assign w_op  = r_ir[31:27];
    assign w_ra  = r_ir[26:23];
    assign w_rb  = r_ir[22:19];
    assign w_rc  = r_ir[18:15];
    assign w_imm = {{(DATA_W-19){r_ir[18]}}, r_ir[18:0]};

    assign w_ra_val = reg_ok(w_ra)    ? r_regs[w_ra[RIDX_W-1:0]]    : '0;
    assign w_rb_val = reg_ok(w_rb)    ? r_regs[w_rb[RIDX_W-1:0]]    : '0;
    assign w_rc_val = reg_ok(w_rc)    ? r_regs[w_rc[RIDX_W-1:0]]    : '0;
    assign dbg_data = reg_ok(dbg_sel) ? r_regs[dbg_sel[RIDX_W-1:0]] : '0;

    // Base-address operand: Rb index 0 reads as zero for ld/ldi/st only.
    assign w_base    = (w_op == OP_LD) || (w_op == OP_LDI) || (w_op == OP_ST);
    assign w_use_imm = w_base || (w_op == OP_ADDI) || (w_op == OP_ANDI);
    assign w_b_val   = (w_base && (w_rb == 4'd0)) ? '0 : w_rb_val;

    assign w_ye   = {{DATA_W{r_y[DATA_W-1]}}, r_y};
    assign w_ze   = {{DATA_W{r_z[DATA_W-1]}}, r_z};
    assign w_prod = w_ye * w_ze;

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: w_alu = r_y + r_z;
            OP_SUB:          w_alu = r_y - r_z;
            OP_AND, OP_ANDI: w_alu = r_y & r_z;
            OP_OR:           w_alu = r_y | r_z;
            OP_SHR:          w_alu = (r_z >= SHIFT_LIM) ? '0 : (r_y >> r_z);
            OP_SHL:          w_alu = (r_z >= SHIFT_LIM) ? '0 : (r_y << r_z);
            OP_IN:           w_alu = in_port;
            OP_MFHI:         w_alu = r_hi;
            OP_MFLO:         w_alu = r_lo;
            default:         w_alu = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = r_pc;
        mem_wdata = '0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH;
            S_HALT:   if (start) w_next = S_FETCH;
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ack) w_next = S_DECODE;
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                case (w_op)
                    OP_LD, OP_ST:                     w_next = S_MEM;
                    OP_MUL, OP_OUT, OP_NOP:           w_next = S_FETCH;
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
                    OP_ADDI, OP_ANDI, OP_IN, OP_MFHI, OP_MFLO: w_next = S_WB;
                    default:                          w_next = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_addr = r_z[ADDR_W-1:0];
                if (w_op == OP_ST) begin
                    mem_write = 1'b1;
                    mem_wdata = w_ra_val;
                    if (mem_ack) w_next = S_FETCH;
                end else begin
                    mem_read = 1'b1;
                    if (mem_ack) w_next = S_WB;
                end
            end
            S_WB:     w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_pc  <= PC_INIT;
            r_ir  <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_out <= '0;
            r_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_HALT: if (start) r_err <= 1'b0;
                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir <= mem_rdata[31:0];
                        r_pc <= r_pc + ADDR_W'(1);
                    end
                end
                S_EXEC: begin
                    if (w_op == OP_MUL) {r_hi, r_lo} <= w_prod;
                    if (w_op == OP_OUT) r_out <= w_ra_val;
                    if (w_op > OP_HALT) r_err <= 1'b1;
                end
                S_WB: if (reg_ok(w_ra)) r_regs[w_ra[RIDX_W-1:0]] <= r_z;
                default: ;
            endcase
        end
    end

    // Operand/result latches carry no reset; they are only consumed via sequenced states.
    always_ff @(posedge clock) begin
        case (r_state)
            S_DECODE: begin
                r_y <= w_b_val;
                r_z <= w_use_imm ? w_imm : w_rc_val;
            end
            S_EXEC:   r_z <= w_alu;
            S_MEM:    if (mem_ack && (w_op == OP_LD)) r_z <= mem_rdata;
            default:  ;
        endcase
    end

    assign out_port = r_out;
    assign err      = r_err;
    assign halted   = (r_state == S_HALT);
    assign busy     = (r_state != S_IDLE) && (r_state != S_HALT);

endmodule

// File: tb/tb_rt_datapath_seq.sv
// Directed bench for rt_datapath_seq with a behavioural variable-latency memory responder.
module tb_rt_datapath_seq;
    logic        clock;
    logic        clear;
    logic        start;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ack;
    logic [31:0] in_port;
    logic [31:0] out_port;
    logic        busy;
    logic        halted;
    logic        err;
    logic [3:0]  dbg_sel;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [512];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic        blk_en    = 1'b0;
    logic [8:0]  blk_addr  = '0;
    logic        force_ack = 1'b0;
    logic [8:0]  rd_log [$];
    int          wr_count  = 0;
    logic [8:0]  wr_addr   = '0;
    logic [31:0] wr_data   = '0;

    rt_datapath_seq #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(9), .RESET_PC(0)) dut (
        .clock(clock), .clear(clear), .start(start),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ack(mem_ack),
        .in_port(in_port), .out_port(out_port), .busy(busy), .halted(halted),
        .err(err), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory responder: acks after ack_delay waiting cycles, requests to blk_addr are withheld.
    always @(negedge clock) begin
        mem_ack = 1'b0;
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
        end else if ((mem_read || mem_write) && !(blk_en && mem_addr == blk_addr)) begin
            if (wait_cnt >= ack_delay) begin
                wait_cnt = 0;
                mem_ack  = 1'b1;
                if (mem_read) begin
                    mem_rdata = mem[mem_addr];
                    rd_log.push_back(mem_addr);
                end else begin
                    mem[mem_addr] = mem_wdata;
                    wr_count++;
                    wr_addr = mem_addr;
                    wr_data = mem_wdata;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    function automatic logic [31:0] ins(input int op, input int ra, input int rb, input int c);
        return {op[4:0], ra[3:0], rb[3:0], c[18:0]};
    endfunction

    function automatic logic [31:0] rr(input int op, input int ra, input int rb, input int rc);
        return ins(op, ra, rb, rc << 15);
    endfunction

    task automatic peek(input int idx, output logic [31:0] v);
        dbg_sel = idx[3:0];
        #1;
        v = dbg_data;
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear     = 1'b1;
        force_ack = 1'b0;
        blk_en    = 1'b0;
        ack_delay = 0;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        rd_log.delete();
        wr_count = 0;
        for (int i = 0; i < 512; i++) mem[i] = ins(17, 0, 0, 0);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic run_to_halt(input string name);
        int k;
        for (k = 0; k < 500; k++) begin
            if (halted) break;
            @(posedge clock);
            #1;
        end
        n_checks++;
        if (!halted) begin
            n_fail++;
            $display("FAIL %s_halt_timeout: halted=%b required 1", name, halted);
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_clear();
        n_checks++; if (mem_addr !== 9'h000) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 000", mem_addr); end
        n_checks++; if ({mem_read, mem_write, busy, halted, err} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {mem_read, mem_write, busy, halted, err}); end
        n_checks++; if (out_port !== 32'h0) begin n_fail++; $display("FAIL reset_out_port: got %h want 0", out_port); end
        peek(15, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_r15: got %h want 0", v); end
    endtask

    task automatic test_basic();
        logic [31:0] v;
        do_clear();
        mem[0] = 32'h0880_0005;
        mem[1] = rr(3, 2, 1, 1);
        dbg_sel = 4'd2;
        pulse_start();
        n_checks++; if ({mem_read, mem_addr} !== {1'b1, 9'h000}) begin n_fail++; $display("FAIL basic_first_fetch: got rd=%b addr=%h want rd=1 addr=000", mem_read, mem_addr); end
        repeat (7) @(posedge clock);
        #1;
        n_checks++; if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL basic_r2_early: got %h want 0", dbg_data); end
        @(posedge clock);
        #1;
        n_checks++; if (dbg_data !== 32'd10) begin n_fail++; $display("FAIL basic_r2_on_time: got %h want 0000000a", dbg_data); end
        run_to_halt("basic");
        peek(1, v);
        n_checks++; if (v !== 32'd5) begin n_fail++; $display("FAIL basic_r1: got %h want 5", v); end
    endtask

    task automatic test_fetch_wait();
        int k;
        do_clear();
        ack_delay = 3;
        mem[0] = ins(16, 0, 0, 0);
        mem[1] = ins(16, 0, 0, 0);
        pulse_start();
        for (k = 0; k < 4; k++) begin
            n_checks++;
            if ({mem_read, mem_addr} !== {1'b1, 9'h000}) begin
                n_fail++; $display("FAIL wait_hold_c%0d: got rd=%b addr=%h want rd=1 addr=000", k, mem_read, mem_addr);
            end
            @(posedge clock);
            #1;
        end
        n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL wait_drop: got rd=%b want 0", mem_read); end
        run_to_halt("wait");
        n_checks++; if (rd_log.size() !== 3) begin n_fail++; $display("FAIL wait_fetch_count: got %0d want 3", rd_log.size()); end
        else begin
            n_checks++; if ({rd_log[0], rd_log[1], rd_log[2]} !== {9'd0, 9'd1, 9'd2}) begin n_fail++; $display("FAIL wait_pc_seq: got %h %h %h want 000 001 002", rd_log[0], rd_log[1], rd_log[2]); end
        end
    endtask

    task automatic test_ld_st();
        logic [31:0] v;
        do_clear();
        mem[0] = ins(1, 1, 0, 5);
        mem[1] = ins(1, 3, 0, 'h7F);
        mem[2] = ins(2, 1, 3, 1);
        mem[3] = ins(0, 4, 3, 1);
        pulse_start();
        run_to_halt("ldst");
        n_checks++; if (wr_count !== 1) begin n_fail++; $display("FAIL ldst_wr_count: got %0d want 1", wr_count); end
        n_checks++; if ({wr_addr, wr_data} !== {9'h080, 32'd5}) begin n_fail++; $display("FAIL ldst_write: got addr=%h data=%h want addr=080 data=5", wr_addr, wr_data); end
        n_checks++; if (rd_log.size() < 5 || rd_log[4] !== 9'h080) begin n_fail++; $display("FAIL ldst_ld_addr: got n=%0d want load read at 080", rd_log.size()); end
        peek(4, v);
        n_checks++; if (v !== 32'd5) begin n_fail++; $display("FAIL ldst_r4: got %h want 5", v); end
    endtask

    task automatic test_mul_shift();
        logic [31:0] v;
        do_clear();
        mem[0]  = ins(1, 5, 0, 'h7FFFF);
        mem[1]  = ins(1, 6, 0, 2);
        mem[2]  = rr(11, 0, 5, 6);
        mem[3]  = ins(14, 7, 0, 0);
        mem[4]  = ins(15, 8, 0, 0);
        mem[5]  = ins(1, 9, 0, 40);
        mem[6]  = ins(1, 10, 0, 1);
        mem[7]  = rr(8, 11, 10, 9);
        mem[8]  = rr(8, 12, 10, 6);
        mem[9]  = rr(7, 13, 5, 10);
        mem[10] = rr(4, 14, 6, 10);
        mem[11] = rr(6, 15, 10, 6);
        pulse_start();
        run_to_halt("alu");
        peek(7, v);  n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mul_hi: got %h want ffffffff", v); end
        peek(8, v);  n_checks++; if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mul_lo: got %h want fffffffe", v); end
        peek(11, v); n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL shl_40: got %h want 0", v); end
        peek(12, v); n_checks++; if (v !== 32'h4) begin n_fail++; $display("FAIL shl_2: got %h want 4", v); end
        peek(13, v); n_checks++; if (v !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL shr_1: got %h want 7fffffff", v); end
        peek(14, v); n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL sub: got %h want 1", v); end
        peek(15, v); n_checks++; if (v !== 32'h3) begin n_fail++; $display("FAIL or: got %h want 3", v); end
    endtask

    task automatic test_io();
        logic [31:0] v;
        do_clear();
        in_port = 32'hA5A5_1234;
        mem[0] = ins(12, 1, 0, 0);
        mem[1] = ins(13, 1, 0, 0);
        pulse_start();
        run_to_halt("io");
        n_checks++; if (out_port !== 32'hA5A5_1234) begin n_fail++; $display("FAIL io_out: got %h want a5a51234", out_port); end
        peek(1, v);
        n_checks++; if (v !== 32'hA5A5_1234) begin n_fail++; $display("FAIL io_in: got %h want a5a51234", v); end
    endtask

    task automatic test_halt_err();
        logic [31:0] v;
        do_clear();
        mem[0] = ins(1, 1, 0, 7);
        mem[1] = ins(25, 0, 0, 0);
        mem[2] = ins(1, 2, 0, 9);
        pulse_start();
        run_to_halt("illegal");
        n_checks++; if ({halted, err, busy} !== 3'b110) begin n_fail++; $display("FAIL illegal_flags: got h/e/b=%b want 110", {halted, err, busy}); end
        pulse_start();
        n_checks++; if ({err, busy, mem_addr} !== {1'b0, 1'b1, 9'h002}) begin n_fail++; $display("FAIL resume: got err=%b busy=%b addr=%h want 0 1 002", err, busy, mem_addr); end
        run_to_halt("halt");
        n_checks++; if ({halted, err} !== 2'b10) begin n_fail++; $display("FAIL halt_flags: got h/e=%b want 10", {halted, err}); end
        peek(2, v);
        n_checks++; if (v !== 32'd9) begin n_fail++; $display("FAIL resume_r2: got %h want 9", v); end
    endtask

    task automatic test_clear_mid_mem();
        logic [31:0] v;
        int          k;
        logic        found;
        do_clear();
        mem[0]  = ins(1, 1, 0, 'h33);
        mem[1]  = ins(13, 1, 0, 0);
        mem[2]  = ins(0, 4, 0, 'h10);
        mem[16] = 32'h0000_1234;
        blk_addr = 9'h010;
        blk_en   = 1'b1;
        pulse_start();
        found = 1'b0;
        for (k = 0; k < 200; k++) begin
            if (mem_read && mem_addr == 9'h010) begin found = 1'b1; break; end
            @(posedge clock);
            #1;
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL clr_reach_mem: got %b want 1", found); end
        n_checks++; if (out_port !== 32'h33) begin n_fail++; $display("FAIL clr_out_before: got %h want 33", out_port); end
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if ({mem_read, busy} !== 2'b11) begin n_fail++; $display("FAIL clr_still_waiting: got rd/busy=%b want 11", {mem_read, busy}); end
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear     = 1'b0;
        force_ack = 1'b1;
        n_checks++; if ({mem_read, busy, halted} !== 3'b000) begin n_fail++; $display("FAIL clr_idle: got rd/busy/halt=%b want 000", {mem_read, busy, halted}); end
        n_checks++; if ({out_port, mem_addr} !== {32'h0, 9'h000}) begin n_fail++; $display("FAIL clr_out_addr: got out=%h addr=%h want 0 000", out_port, mem_addr); end
        @(posedge clock);
        #1;
        force_ack = 1'b0;
        blk_en    = 1'b0;
        n_checks++; if ({mem_read, busy} !== 2'b00) begin n_fail++; $display("FAIL clr_late_ack: got rd/busy=%b want 00", {mem_read, busy}); end
        peek(4, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL clr_r4: got %h want 0", v); end
        peek(1, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL clr_r1: got %h want 0", v); end
    endtask

    initial begin
        clear     = 1'b1;
        start     = 1'b0;
        in_port   = '0;
        dbg_sel   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        test_reset();
        test_basic();
        test_fetch_wait();
        test_ld_st();
        test_mul_shift();
        test_io();
        test_halt_err();
        test_clear_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
